// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory controller slice.
package dmem_pkg;

  localparam int WAIT_W          = 3;
  localparam int DEF_DATA_W      = 16;
  localparam int DEF_ADDR_W      = 16;
  localparam int DEF_DEPTH       = 8;
  localparam int DEF_WAIT_STATES = 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  // Index width, kept at least 1 so a single-word memory still has a port.
  function automatic int idx_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Word storage with byte-lane writes and a registered read port; read data
// only changes when rd_en is high, so it holds across response backpressure.
module dmem_array #(
  parameter int    DATA_W    = 16,
  parameter int    DEPTH     = 8,
  parameter int    IDX_W     = 3,
  parameter string INIT_FILE = ""
) (
  input  logic                clk,
  input  logic                wr_en,
  input  logic                rd_en,
  input  logic [IDX_W-1:0]    idx,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W/8-1:0] be,
  output logic [DATA_W-1:0]   rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < DATA_W/8; i++) begin
        if (be[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
    if (rd_en) rdata <= mem[idx];
  end

endmodule

// File: rtl/dmem_ctrl.sv
// Single-outstanding memory controller: response WAIT_STATES+1 cycles after accept,
// held until rsp_ready; no new request is taken until the response is consumed.
module dmem_ctrl
  import dmem_pkg::*;
#(
  parameter int    DATA_W      = DEF_DATA_W,
  parameter int    ADDR_W      = DEF_ADDR_W,
  parameter int    DEPTH       = DEF_DEPTH,
  parameter int    WAIT_STATES = DEF_WAIT_STATES,
  parameter string INIT_FILE   = ""
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [DATA_W/8-1:0] req_be,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_err
);

  localparam int              IDX_W   = idx_w(DEPTH);
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

  state_t              state_q, state_d;
  logic [WAIT_W-1:0]   cnt_q;
  logic                we_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W/8-1:0] be_q;
  logic                rsp_err_q;
  logic                rsp_rd_q;
  logic                access;
  logic                in_range;
  logic [DATA_W-1:0]   arr_rdata;

  assign in_range = ({1'b0, addr_q} < DEPTH_L);

  always_comb begin
    state_d   = state_q;
    req_ready = 1'b0;
    access    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_d = ST_ACCESS;
      end
      ST_ACCESS: begin
        if (cnt_q == '0) begin
          access  = 1'b1;
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        if (rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      be_q      <= '0;
      rsp_err_q <= 1'b0;
      rsp_rd_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_IDLE && req_valid) begin
        we_q    <= req_we;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        be_q    <= req_be;
        cnt_q   <= WAIT_W'(WAIT_STATES);
      end else if (state_q == ST_ACCESS && cnt_q != '0) begin
        cnt_q <= cnt_q - WAIT_W'(1);
      end
      if (access) begin
        rsp_err_q <= !in_range;
        rsp_rd_q  <= !we_q && in_range;
      end
    end
  end

  // Reset gates the array strobes so a reset on the access edge commits nothing.
  dmem_array #(
    .DATA_W   (DATA_W),
    .DEPTH    (DEPTH),
    .IDX_W    (IDX_W),
    .INIT_FILE(INIT_FILE)
  ) u_array (
    .clk  (clk),
    .wr_en(access && we_q && in_range && !rst),
    .rd_en(access && !we_q && in_range && !rst),
    .idx  (addr_q[IDX_W-1:0]),
    .wdata(wdata_q),
    .be   (be_q),
    .rdata(arr_rdata)
  );

  assign rsp_valid = (state_q == ST_RESP);
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rsp_rd_q ? arr_rdata : '0;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Four controllers (WAIT_STATES 1,0,7,3) driven by directed and random transactions
// against a per-instance memory model.
module tb_dmem_ctrl;

  localparam int ND = 4;
  localparam int WS [ND] = '{1, 0, 7, 3};

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid [ND];
  logic        req_ready [ND];
  logic        req_we    [ND];
  logic [15:0] req_addr  [ND];
  logic [15:0] req_wdata [ND];
  logic [1:0]  req_be    [ND];
  logic        rsp_valid [ND];
  logic        rsp_ready [ND];
  logic [15:0] rsp_rdata [ND];
  logic        rsp_err   [ND];

  logic [15:0] mm [ND][8];
  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < ND; g++) begin : g_dut
    dmem_ctrl #(
      .DATA_W(16), .ADDR_W(16), .DEPTH(8),
      .WAIT_STATES(g == 0 ? 1 : g == 1 ? 0 : g == 2 ? 7 : 3),
      .INIT_FILE("")
    ) u_dut (
      .clk      (clk),
      .rst      (rst),
      .req_valid(req_valid[g]),
      .req_ready(req_ready[g]),
      .req_we   (req_we[g]),
      .req_addr (req_addr[g]),
      .req_wdata(req_wdata[g]),
      .req_be   (req_be[g]),
      .rsp_valid(rsp_valid[g]),
      .rsp_ready(rsp_ready[g]),
      .rsp_rdata(rsp_rdata[g]),
      .rsp_err  (rsp_err[g])
    );
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One full transaction on instance d; response held back for 'hold' cycles.
  task automatic txn(input int d, input bit we, input logic [15:0] addr,
                     input logic [15:0] wdata, input logic [1:0] be,
                     input int hold, output logic [15:0] got);
    logic [15:0] exp_rd;
    bit          exp_err;
    int          lat;
    exp_err = (addr >= 16'd8);
    exp_rd  = (!we && !exp_err) ? mm[d][addr[2:0]] : 16'h0;
    @(negedge clk);
    chk("req_ready_idle", 32'(req_ready[d]), 32'd1);
    req_valid[d] = 1'b1; req_we[d] = we; req_addr[d] = addr;
    req_wdata[d] = wdata; req_be[d] = be;
    @(negedge clk);
    req_valid[d] = 1'b0;
    req_addr[d]  = 16'($urandom);
    req_wdata[d] = 16'($urandom);
    req_be[d]    = 2'($urandom);
    req_we[d]    = 1'($urandom);
    lat = 0;
    while (!rsp_valid[d] && lat < 12) begin
      chk("req_ready_busy", 32'(req_ready[d]), 32'd0);
      @(negedge clk);
      lat++;
    end
    chk("latency", 32'(lat), 32'(WS[d] + 1));
    chk("rsp_err", 32'(rsp_err[d]), 32'(exp_err));
    chk("rsp_rdata", 32'(rsp_rdata[d]), 32'(exp_rd));
    got = rsp_rdata[d];
    if (we && !exp_err) begin
      if (be[0]) mm[d][addr[2:0]][7:0]  = wdata[7:0];
      if (be[1]) mm[d][addr[2:0]][15:8] = wdata[15:8];
    end
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("hold_valid", 32'(rsp_valid[d]), 32'd1);
      chk("hold_rdata", 32'(rsp_rdata[d]), 32'(exp_rd));
      chk("hold_err", 32'(rsp_err[d]), 32'(exp_err));
      chk("hold_req_ready", 32'(req_ready[d]), 32'd0);
    end
    rsp_ready[d] = 1'b1;
    @(negedge clk);
    rsp_ready[d] = 1'b0;
    chk("post_hs_req_ready", 32'(req_ready[d]), 32'd1);
    chk("post_hs_valid", 32'(rsp_valid[d]), 32'd0);
  endtask

  // Write on instance 3, then reset asserted so it is sampled 'k' edges after accept.
  task automatic rst_abort(input logic [15:0] addr, input int k);
    @(negedge clk);
    req_valid[3] = 1'b1; req_we[3] = 1'b1; req_addr[3] = addr;
    req_wdata[3] = ~mm[3][addr[2:0]]; req_be[3] = 2'b11;
    @(negedge clk);
    req_valid[3] = 1'b0;
    for (int i = 1; i < k; i++) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_req_ready", 32'(req_ready[3]), 32'd1);
    chk("abort_valid", 32'(rsp_valid[3]), 32'd0);
    chk("abort_rdata", 32'(rsp_rdata[3]), 32'd0);
    chk("abort_err", 32'(rsp_err[3]), 32'd0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("abort_no_rsp", 32'(rsp_valid[3]), 32'd0);
    end
  endtask

  initial begin
    logic [15:0] got;
    int          acc [$];
    int          wr_cnt;
    for (int d = 0; d < ND; d++) begin
      req_valid[d] = 1'b0; req_we[d] = 1'b0; req_addr[d] = '0;
      req_wdata[d] = '0;   req_be[d] = '0;   rsp_ready[d] = 1'b0;
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    for (int d = 0; d < ND; d++) begin
      chk("rst_req_ready", 32'(req_ready[d]), 32'd1);
      chk("rst_valid", 32'(rsp_valid[d]), 32'd0);
      chk("rst_rdata", 32'(rsp_rdata[d]), 32'd0);
      chk("rst_err", 32'(rsp_err[d]), 32'd0);
    end

    for (int d = 0; d < ND; d++)
      for (int a = 0; a < 8; a++) txn(d, 1'b1, 16'(a), 16'($urandom), 2'b11, 0, got);

    txn(0, 1'b1, 16'd3, 16'hBEEF, 2'b11, 0, got);
    chk("beef_wr_rdata", 32'(got), 32'd0);
    txn(0, 1'b0, 16'd3, 16'h0, 2'b00, 0, got);
    chk("beef_rd", 32'(got), 32'hBEEF);

    txn(0, 1'b1, 16'd5, 16'h1234, 2'b11, 0, got);
    txn(0, 1'b1, 16'd5, 16'hABCD, 2'b01, 0, got);
    txn(0, 1'b0, 16'd5, 16'h0, 2'b00, 0, got);
    chk("lane_rd", 32'(got), 32'h12CD);
    txn(0, 1'b1, 16'd5, 16'h5555, 2'b00, 0, got);
    txn(0, 1'b0, 16'd5, 16'h0, 2'b00, 0, got);
    chk("be0_rd", 32'(got), 32'h12CD);

    txn(0, 1'b0, 16'd8, 16'h0, 2'b00, 0, got);
    txn(0, 1'b1, 16'h0009, 16'hFFFF, 2'b11, 0, got);
    txn(0, 1'b1, 16'h8001, 16'hFFFF, 2'b11, 0, got);
    txn(0, 1'b0, 16'd1, 16'h0, 2'b00, 0, got);

    txn(1, 1'b0, 16'd2, 16'h0, 2'b00, 3, got);
    txn(2, 1'b1, 16'd4, 16'h7E57, 2'b10, 3, got);
    txn(2, 1'b0, 16'd4, 16'h0, 2'b00, 3, got);

    rst_abort(16'd2, 2);
    txn(3, 1'b0, 16'd2, 16'h0, 2'b00, 0, got);
    rst_abort(16'd6, 4);
    txn(3, 1'b0, 16'd6, 16'h0, 2'b00, 0, got);

    for (int d = 0; d < ND; d++)
      for (int i = 0; i < 40; i++)
        txn(d, 1'($urandom), 16'($urandom_range(0, 11)), 16'($urandom),
            2'($urandom), $urandom_range(0, 2), got);

    // Streaming: request always present, consumer always ready.
    @(negedge clk);
    req_valid[0] = 1'b1; req_we[0] = 1'b0; req_addr[0] = 16'd3; rsp_ready[0] = 1'b1;
    wr_cnt = 0;
    for (int c = 0; c < 30; c++) begin
      if (req_ready[0]) acc.push_back(c);
      if (rsp_valid[0]) begin
        wr_cnt++;
        chk("stream_rdata", 32'(rsp_rdata[0]), 32'(mm[0][3]));
      end
      @(negedge clk);
    end
    req_valid[0] = 1'b0;
    repeat (5) @(negedge clk);
    rsp_ready[0] = 1'b0;
    chk("stream_accepts", 32'(acc.size()), 32'd8);
    chk("stream_rsps", 32'(wr_cnt), 32'(acc.size() > 0 ? acc.size() - 1 : 0) + 32'd0);
    for (int i = 1; i < acc.size(); i++)
      chk("stream_gap", 32'(acc[i] - acc[i-1]), 32'd4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
